// File: rtl/reg_writeback_unit_pkg.sv
// Shared encodings for the writeback stage: result selects, load types and FSM states.
package reg_writeback_unit_pkg;

   localparam logic [2:0] WB_X   = 3'd0;
   localparam logic [2:0] WB_ALU = 3'd1;
   localparam logic [2:0] WB_MEM = 3'd2;
   localparam logic [2:0] WB_PC  = 3'd3;
   localparam logic [2:0] WB_CSR = 3'd4;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_MEM = 2'd1,
      ST_COMMIT   = 2'd2
   } wb_state_t;

   // Result for every non-load select; unknown selects write zero.
   function automatic logic [31:0] select_value(input logic [2:0]  sel,
                                                input logic [31:0] alu,
                                                input logic [31:0] pc,
                                                input logic [31:0] csr);
      logic [31:0] v;
      case (sel)
         WB_ALU:  v = alu;
         WB_PC:   v = pc + 32'd4;
         WB_CSR:  v = csr;
         default: v = 32'd0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/reg_writeback_unit_load_extend.sv
// Load data alignment and sign/zero extension, plus the misalignment check for the load type.
module load_extend
   import reg_writeback_unit_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] rdata,
   output logic [31:0] value,
   output logic        misaligned
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rdata[{off, 3'b000} +: 8];
   assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      value      = 32'd0;
      misaligned = 1'b0;
      case (funct3)
         F3_LB:  value = {{24{byte_sel[7]}}, byte_sel};
         F3_LH: begin
            value      = {{16{half_sel[15]}}, half_sel};
            misaligned = off[0];
         end
         F3_LW: begin
            value      = rdata;
            misaligned = (off != 2'b00);
         end
         F3_LBU: value = {24'd0, byte_sel};
         F3_LHU: begin
            value      = {16'd0, half_sel};
            misaligned = off[0];
         end
         default: value = 32'd0;
      endcase
   end

endmodule

// File: rtl/reg_writeback_unit.sv
// Writeback stage: accepts one retiring instruction per handshake and drives a single
// registered register-file write pulse per instruction (or an error pulse for bad loads).
module reg_writeback_unit
   import reg_writeback_unit_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        rf_wen,
   input  logic [4:0]  rd_addr,
   input  logic [2:0]  wb_sel,
   input  logic [31:0] alu_out,
   input  logic [31:0] pc,
   input  logic [31:0] csr_rdata,
   input  logic [2:0]  mem_funct3,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        write_en,
   output logic [4:0]  write_addr,
   output logic [31:0] write_value,
   output logic        wb_err
);

   localparam int CTR_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CTR_W-1:0] CTR_LIMIT = CTR_W'(MEM_TIMEOUT - 1);

   wb_state_t   state_reg, state_next;
   logic [CTR_W-1:0] ctr_reg, ctr_next;
   logic        write_en_reg, write_en_next;
   logic [4:0]  write_addr_reg, write_addr_next;
   logic [31:0] write_value_reg, write_value_next;
   logic        wb_err_reg, wb_err_next;

   // Fields a pending load still needs once it leaves the input bus.
   logic        rf_wen_reg;
   logic [4:0]  rd_reg;
   logic [2:0]  funct3_reg;
   logic [1:0]  off_reg;

   logic        accept;
   logic [31:0] load_value;
   logic        load_misaligned;

   assign in_ready = (state_reg != ST_WAIT_MEM);
   assign accept   = in_valid & in_ready;

   load_extend u_load_extend (
      .funct3     (funct3_reg),
      .off        (off_reg),
      .rdata      (mem_rdata),
      .value      (load_value),
      .misaligned (load_misaligned)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= ST_IDLE;
         ctr_reg         <= '0;
         write_en_reg    <= 1'b0;
         write_addr_reg  <= 5'd0;
         write_value_reg <= 32'd0;
         wb_err_reg      <= 1'b0;
         rf_wen_reg      <= 1'b0;
         rd_reg          <= 5'd0;
         funct3_reg      <= 3'd0;
         off_reg         <= 2'd0;
      end else begin
         state_reg       <= state_next;
         ctr_reg         <= ctr_next;
         write_en_reg    <= write_en_next;
         write_addr_reg  <= write_addr_next;
         write_value_reg <= write_value_next;
         wb_err_reg      <= wb_err_next;
         if (accept) begin
            rf_wen_reg <= rf_wen;
            rd_reg     <= rd_addr;
            funct3_reg <= mem_funct3;
            off_reg    <= alu_out[1:0];
         end
      end
   end

   always_comb begin
      state_next       = state_reg;
      ctr_next         = ctr_reg;
      write_en_next    = 1'b0;
      write_addr_next  = write_addr_reg;
      write_value_next = write_value_reg;
      wb_err_next      = 1'b0;
      case (state_reg)
         ST_WAIT_MEM: begin
            // Data arriving on the timeout cycle still commits.
            if (mem_rvalid) begin
               if (load_misaligned) begin
                  wb_err_next = 1'b1;
                  state_next  = ST_IDLE;
               end else begin
                  state_next = ST_COMMIT;
                  if (rf_wen_reg && (rd_reg != 5'd0)) begin
                     write_en_next    = 1'b1;
                     write_addr_next  = rd_reg;
                     write_value_next = load_value;
                  end
               end
            end else if (ctr_reg == CTR_LIMIT) begin
               wb_err_next = 1'b1;
               state_next  = ST_IDLE;
            end else begin
               ctr_next = ctr_reg + 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
            if (accept) begin
               if (wb_sel == WB_MEM) begin
                  state_next = ST_WAIT_MEM;
                  ctr_next   = '0;
               end else begin
                  state_next = ST_COMMIT;
                  if (rf_wen && (rd_addr != 5'd0)) begin
                     write_en_next    = 1'b1;
                     write_addr_next  = rd_addr;
                     write_value_next = select_value(wb_sel, alu_out, pc, csr_rdata);
                  end
               end
            end
         end
      endcase
   end

   assign write_en    = write_en_reg;
   assign write_addr  = write_addr_reg;
   assign write_value = write_value_reg;
   assign wb_err      = wb_err_reg;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit (MEM_TIMEOUT=4): ALU/PC/CSR writes, loads, x0, errors, reset.
module tb_reg_writeback_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        rf_wen;
   logic [4:0]  rd_addr;
   logic [2:0]  wb_sel;
   logic [31:0] alu_out;
   logic [31:0] pc;
   logic [31:0] csr_rdata;
   logic [2:0]  mem_funct3;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        write_en;
   logic [4:0]  write_addr;
   logic [31:0] write_value;
   logic        wb_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reg_writeback_unit #(.MEM_TIMEOUT(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .rf_wen      (rf_wen),
      .rd_addr     (rd_addr),
      .wb_sel      (wb_sel),
      .alu_out     (alu_out),
      .pc          (pc),
      .csr_rdata   (csr_rdata),
      .mem_funct3  (mem_funct3),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .write_en    (write_en),
      .write_addr  (write_addr),
      .write_value (write_value),
      .wb_err      (wb_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_write(input string tag, input logic en, input logic [4:0] addr,
                              input logic [31:0] val, input logic err);
      $display("txn %s: write_en=%0b addr=%0d value=%h wb_err=%0b",
               tag, write_en, write_addr, write_value, wb_err);
      chk({tag, ".en"}, {31'd0, write_en}, {31'd0, en});
      chk({tag, ".addr"}, {27'd0, write_addr}, {27'd0, addr});
      chk({tag, ".value"}, write_value, val);
      chk({tag, ".err"}, {31'd0, wb_err}, {31'd0, err});
   endtask

   task automatic present(input logic [2:0] sel, input logic [4:0] rd, input logic [31:0] alu,
                          input logic [31:0] pcv, input logic [31:0] csr, input logic [2:0] f3);
      in_valid   = 1'b1;
      rf_wen     = 1'b1;
      wb_sel     = sel;
      rd_addr    = rd;
      alu_out    = alu;
      pc         = pcv;
      csr_rdata  = csr;
      mem_funct3 = f3;
   endtask

   // Accept a load, wait n cycles, pulse rvalid; returns in the cycle after the rvalid edge.
   task automatic load_op(input logic [2:0] f3, input logic [31:0] alu, input logic [4:0] rd,
                          input logic [31:0] rdata, input int n);
      present(3'd2, rd, alu, 32'd0, 32'd0, f3);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      tick();
      mem_rvalid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; rf_wen = 1'b0; rd_addr = 5'd0; wb_sel = 3'd0;
      alu_out = 32'd0; pc = 32'd0; csr_rdata = 32'd0; mem_funct3 = 3'd0;
      mem_rvalid = 1'b0; mem_rdata = 32'd0;
      tick(); tick();
      reset = 1'b0;
      check_write("reset", 1'b0, 5'd0, 32'd0, 1'b0);
      chk("reset.ready", {31'd0, in_ready}, 32'd1);

      // ALU result one cycle after accept, then outputs hold.
      present(3'd1, 5'd5, 32'h1234, 32'd0, 32'd0, 3'd0);
      tick();
      in_valid = 1'b0;
      check_write("alu", 1'b1, 5'd5, 32'h1234, 1'b0);
      tick();
      check_write("alu_hold", 1'b0, 5'd5, 32'h1234, 1'b0);

      // LB with rvalid three cycles after accept; in_ready low while waiting.
      present(3'd2, 5'd7, 32'h103, 32'd0, 32'd0, 3'b000);
      tick();
      in_valid = 1'b0;
      chk("lb.wait_ready", {31'd0, in_ready}, 32'd0);
      chk("lb.wait_en", {31'd0, write_en}, 32'd0);
      tick(); tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0000;
      tick();
      mem_rvalid = 1'b0;
      check_write("lb", 1'b1, 5'd7, 32'hFFFF_FF80, 1'b0);
      tick();
      chk("lb.after_en", {31'd0, write_en}, 32'd0);
      chk("lb.after_ready", {31'd0, in_ready}, 32'd1);

      load_op(3'b101, 32'h2, 5'd8, 32'h8001_7FFF, 0);
      check_write("lhu", 1'b1, 5'd8, 32'h0000_8001, 1'b0);
      load_op(3'b001, 32'h0, 5'd8, 32'h1234_8765, 1);
      check_write("lh", 1'b1, 5'd8, 32'hFFFF_8765, 1'b0);
      load_op(3'b100, 32'h1, 5'd8, 32'h0000_A500, 0);
      check_write("lbu", 1'b1, 5'd8, 32'h0000_00A5, 1'b0);
      load_op(3'b011, 32'h0, 5'd8, 32'hFFFF_FFFF, 0);
      check_write("bad_f3", 1'b1, 5'd8, 32'd0, 1'b0);

      // x0 is never written; PC+4 wraps; CSR passes through.
      present(3'd1, 5'd0, 32'h55, 32'd0, 32'd0, 3'd0);
      tick();
      in_valid = 1'b0;
      check_write("x0", 1'b0, 5'd8, 32'd0, 1'b0);
      present(3'd3, 5'd1, 32'd0, 32'hFFFF_FFFC, 32'd0, 3'd0);
      tick();
      in_valid = 1'b0;
      check_write("pc_wrap", 1'b1, 5'd1, 32'd0, 1'b0);
      present(3'd4, 5'd3, 32'd0, 32'h100, 32'hDEAD_BEEF, 3'd0);
      tick();
      in_valid = 1'b0;
      check_write("csr", 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0);

      // Stray rvalid in IDLE is ignored.
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
      tick();
      mem_rvalid = 1'b0;
      check_write("stray_rvalid", 1'b0, 5'd3, 32'hDEAD_BEEF, 1'b0);

      // Timeout: an ALU instr held upstream during WAIT_MEM is accepted only afterwards.
      present(3'd2, 5'd9, 32'h100, 32'd0, 32'd0, 3'b010);
      tick();
      present(3'd1, 5'd4, 32'h4444, 32'd0, 32'd0, 3'd0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         check_write($sformatf("timeout_wait%0d", i), 1'b0, 5'd3, 32'hDEAD_BEEF, 1'b0);
         chk($sformatf("timeout_ready%0d", i), {31'd0, in_ready}, 32'd0);
      end
      tick();
      check_write("timeout", 1'b0, 5'd3, 32'hDEAD_BEEF, 1'b1);
      chk("timeout.ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      check_write("held_alu", 1'b1, 5'd4, 32'h4444, 1'b0);

      // rvalid on the limit cycle commits without error.
      load_op(3'b010, 32'h200, 5'd10, 32'hCAFE_F00D, 3);
      check_write("limit_rvalid", 1'b1, 5'd10, 32'hCAFE_F00D, 1'b0);

      // Misaligned loads: error pulse, no write.
      load_op(3'b010, 32'h2, 5'd11, 32'h7777_7777, 1);
      check_write("mis_lw", 1'b0, 5'd10, 32'hCAFE_F00D, 1'b1);
      load_op(3'b001, 32'h1, 5'd11, 32'h7777_7777, 0);
      check_write("mis_lh", 1'b0, 5'd10, 32'hCAFE_F00D, 1'b1);
      tick();
      chk("mis.err_clear", {31'd0, wb_err}, 32'd0);

      // Back-to-back ALU instrs every cycle.
      for (int i = 0; i < 3; i++) begin
         present(3'd1, 5'(20 + i), 32'hA000 + 32'(i), 32'd0, 32'd0, 3'd0);
         tick();
         check_write($sformatf("b2b%0d", i), 1'b1, 5'(20 + i), 32'hA000 + 32'(i), 1'b0);
      end
      in_valid = 1'b0;

      // Reset during WAIT_MEM drops the pending load.
      present(3'd2, 5'd12, 32'h0, 32'd0, 32'd0, 3'b010);
      tick();
      in_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_write("reset_mid", 1'b0, 5'd0, 32'd0, 1'b0);
      chk("reset_mid.ready", {31'd0, in_ready}, 32'd1);
      mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      tick();
      mem_rvalid = 1'b0;
      check_write("reset_mid_rvalid", 1'b0, 5'd0, 32'd0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
